pool_unit: RTL

Parametrised, streaming successor to the single-window max-pool node in the CNN accelerator datapath. Per pooling window it consumes KERNAL_SIZE² input beats, each beat carrying one DATA_WIDTH-bit signed value for each of DEPTH channels. It then emits one pooled beat, either max or average as selected per window. It sits between a conv layer's output stream and the next layer's input buffer, with valid/ready handshakes on both sides so it tolerates backpressure.

---
 rtl/pool_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pool_unit.sv
// Streaming max/average pooling over KERNAL_SIZE^2 beats of DEPTH signed channels.
// Average datapath is built only when POOL_AVG_EN is defined; otherwise mode is ignored.
module pool_unit #(
  parameter int KERNAL_SIZE = 2,
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0] neuron_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] neuron_out
);

  localparam int N  = KERNAL_SIZE * KERNAL_SIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
`ifdef POOL_AVG_EN
  localparam int SHIFT = $clog2(N);
  localparam int AW    = DATA_WIDTH + SHIFT;
`else
  localparam int AW    = DATA_WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef POOL_AVG_EN
  if ((1 << $clog2(KERNAL_SIZE)) != KERNAL_SIZE) begin : g_ks_check
    $error("pool_unit: KERNAL_SIZE must be a power of two when averaging is enabled");
  end
`endif

  logic [CW-1:0]               cnt;
  logic signed [AW-1:0]        acc      [DEPTH];
  logic signed [AW-1:0]        acc_next [DEPTH];
  logic signed [AW-1:0]        sext     [DEPTH];
  logic [DEPTH*DATA_WIDTH-1:0] result;
  logic                        first;
  logic                        last;
  logic                        accept;
  logic                        close;

`ifdef POOL_AVG_EN
  logic win_mode;
  logic cur_mode;
  // The window's mode comes straight from the input on its first beat, so N = 1 works too.
  assign cur_mode = first ? mode : win_mode;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign first    = (cnt == '0);
  assign last     = (cnt == LAST);
  assign in_ready = !clr && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign close    = accept && last;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      sext[i] = AW'($signed(neuron_in[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (first) begin
        acc_next[i] = sext[i];
`ifdef POOL_AVG_EN
      end else if (cur_mode) begin
        acc_next[i] = acc[i] + sext[i];
`endif
      end else begin
        acc_next[i] = (acc[i] > sext[i]) ? acc[i] : sext[i];
      end
    end
  end

  always_comb begin
    result = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef POOL_AVG_EN
      if (cur_mode) begin
        result[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc_next[i] >>> SHIFT);
      end else begin
        result[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc_next[i]);
      end
`else
      result[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(acc_next[i]);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      neuron_out <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
      end
`ifdef POOL_AVG_EN
      win_mode   <= 1'b0;
`endif
    end else begin
      if (clr) begin
        cnt <= '0;
      end else if (accept) begin
        cnt <= last ? '0 : cnt + CW'(1);
        for (int unsigned i = 0; i < DEPTH; i++) begin
          acc[i] <= acc_next[i];
        end
`ifdef POOL_AVG_EN
        if (first) begin
          win_mode <= mode;
        end
`endif
      end

      // A closing beat only gets through when the output slot is free or draining this cycle.
      if (close) begin
        out_valid  <= 1'b1;
        neuron_out <= result;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
